// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the PC register it drives.
package pc_fetch_sequencer_pkg;

    localparam int unsigned PC_ADDR_WIDTH = 24;
    localparam int unsigned PC_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

    function automatic int unsigned wait_count_width(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_timer.sv
// Wait counter for an outstanding fetch; expired flags the cycle whose increment reaches MAX_WAIT.
module fetch_wait_timer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CNT_W = wait_count_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: drives PC load/next-address, fetches over req/ack and hands words to decode.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PC_DATA_WIDTH,
    parameter int unsigned INSTR_STEP = 1,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_load_en,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  stall,
    output logic                  fetch_err
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_STEP);

    fetch_state_e          state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  pc_load_en_q, pc_load_en_d;
    logic [ADDR_WIDTH-1:0] pc_next_q, pc_next_d;
    logic                  fetch_err_q, fetch_err_d;
    logic                  discard_q, discard_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;
        pc_load_en_d  = 1'b0;
        pc_next_d     = pc_next_q;
        fetch_err_d   = fetch_err_q;
        discard_d     = discard_q;
        timer_clear   = 1'b0;
        timer_enable  = 1'b0;

        // Redirect load applies in every live state; the sequential load below never overrides it.
        if (branch_valid && state_q != ST_ERR) begin
            pc_load_en_d = 1'b1;
            pc_next_d    = branch_target;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!branch_valid && !stall) begin
                    state_d     = ST_REQ;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = pc_in;
                    timer_clear = 1'b1;
                end
            end
            ST_REQ: begin
                timer_enable = !mem_ack;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (discard_q || branch_valid) begin
                        discard_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        instr_data_d  = mem_rdata;
                        instr_pc_d    = mem_addr_q;
                        instr_valid_d = 1'b1;
                        pc_load_en_d  = 1'b1;
                        pc_next_d     = mem_addr_q + STEP;
                        state_d       = ST_HOLD;
                    end
                end else if (timer_expired) begin
                    fetch_err_d = 1'b1;
                    mem_req_d   = 1'b0;
                    discard_d   = 1'b0;
                    state_d     = ST_ERR;
                end else if (branch_valid) begin
                    discard_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (branch_valid || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
            pc_load_en_q  <= 1'b0;
            pc_next_q     <= '0;
            fetch_err_q   <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
            pc_load_en_q  <= pc_load_en_d;
            pc_next_q     <= pc_next_d;
            fetch_err_q   <= fetch_err_d;
            discard_q     <= discard_d;
        end
    end

    assign pc_load_en  = pc_load_en_q;
    assign pc_next     = pc_next_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: PC register and memory models plus a fetch-stream scoreboard.
module tb_pc_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] pc_in;
    logic        pc_load_en;
    logic [23:0] pc_next;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [23:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        branch_valid = 1'b0;
    logic [23:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    // PC register model: loads on the falling edge after the strobe
    logic [23:0] pc_reg;
    logic        pc_set_req = 1'b0;
    logic [23:0] pc_set_val = '0;

    // Memory model controls
    int unsigned mem_lat = 2;
    bit          mem_rand_lat = 1'b0;
    bit          mem_mute = 1'b0;
    logic        inj_ack = 1'b0;
    logic        mem_ack_m = 1'b0;
    int unsigned req_cycles = 0;
    int unsigned lat_now = 2;

    always #5 clock = ~clock;

    pc_fetch_sequencer #(
        .ADDR_WIDTH(24),
        .DATA_WIDTH(32),
        .INSTR_STEP(1),
        .MAX_WAIT(15)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_in         (pc_in),
        .pc_load_en    (pc_load_en),
        .pc_next       (pc_next),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .stall         (stall),
        .fetch_err     (fetch_err)
    );

    function automatic logic [31:0] word_of(input logic [23:0] a);
        return {a[7:0], a} ^ 32'hC3A5_5A3C;
    endfunction

    assign pc_in   = pc_reg;
    assign mem_ack = mem_ack_m | inj_ack;

    always @(negedge clock) begin
        if (pc_set_req) pc_reg <= pc_set_val;
        else if (pc_load_en) pc_reg <= pc_next;
    end

    always @(posedge clock) begin
        if (reset || !mem_req || mem_ack_m) begin
            req_cycles <= 0;
            mem_ack_m  <= 1'b0;
            lat_now    <= mem_rand_lat ? $urandom_range(1, 8) : mem_lat;
        end else begin
            req_cycles <= req_cycles + 1;
            if (!mem_mute && (req_cycles + 1 >= lat_now)) begin
                mem_ack_m <= 1'b1;
                mem_rdata <= word_of(mem_addr);
            end
        end
    end

    task automatic do_reset(input logic [23:0] start_pc);
        reset = 1'b1;
        branch_valid = 1'b0;
        inj_ack = 1'b0;
        pc_set_val = start_pc;
        pc_set_req = 1'b1;
        @(negedge clock);
        #1 pc_set_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_req(input bit want_rise, output bit ok, output bit saw_valid);
        int unsigned n;
        bit seen_low;
        n = 0;
        ok = 1'b0;
        saw_valid = 1'b0;
        seen_low = !want_rise || !mem_req;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (instr_valid) saw_valid = 1'b1;
            if (!mem_req) seen_low = 1'b1;
            else if (seen_low) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_mem_req: no request within 40 cycles, got mem_req=%0b want 1", mem_req);
        end
    endtask

    task automatic wait_valid(output bit ok);
        int unsigned n;
        n = 0;
        ok = 1'b0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_instr_valid: none within 40 cycles, got instr_valid=%0b want 1", instr_valid);
        end
    endtask

    task automatic pulse_branch(input logic [23:0] tgt);
        @(posedge clock);
        #1;
        branch_valid = 1'b1;
        branch_target = tgt;
        @(posedge clock);
        #1;
        branch_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, instr_valid, instr_data, instr_pc, pc_load_en, pc_next, fetch_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%0b addr=%h v=%0b d=%h ipc=%h ld=%0b nx=%h err=%0b want all 0",
                     mem_req, mem_addr, instr_valid, instr_data, instr_pc, pc_load_en, pc_next, fetch_err);
        end
    endtask

    task automatic test_sequential();
        bit ok, sv;
        mem_lat = 2;
        instr_ready = 1'b1;
        do_reset(24'h000010);
        wait_req(1'b0, ok, sv);
        checks++;
        if (mem_addr !== 24'h000010) begin
            failures++;
            $display("FAIL seq_mem_addr: got %h want 000010", mem_addr);
        end
        wait_valid(ok);
        checks++;
        if (instr_pc !== 24'h000010 || instr_data !== word_of(24'h000010)) begin
            failures++;
            $display("FAIL seq_instr: got pc=%h data=%h want pc=000010 data=%h", instr_pc, instr_data,
                     word_of(24'h000010));
        end
        checks++;
        if (pc_load_en !== 1'b1 || pc_next !== 24'h000011) begin
            failures++;
            $display("FAIL seq_pc_load: got ld=%0b next=%h want ld=1 next=000011", pc_load_en, pc_next);
        end
        wait_req(1'b1, ok, sv);
        checks++;
        if (mem_addr !== 24'h000011) begin
            failures++;
            $display("FAIL seq_next_addr: got %h want 000011", mem_addr);
        end
    endtask

    task automatic test_wrap();
        bit ok, sv;
        mem_lat = 2;
        instr_ready = 1'b1;
        do_reset(24'hFFFFFF);
        wait_valid(ok);
        checks++;
        if (pc_load_en !== 1'b1 || pc_next !== 24'h000000 || instr_pc !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL wrap_pc_next: got ld=%0b next=%h ipc=%h want ld=1 next=000000 ipc=ffffff",
                     pc_load_en, pc_next, instr_pc);
        end
        wait_req(1'b1, ok, sv);
        checks++;
        if (mem_addr !== 24'h000000) begin
            failures++;
            $display("FAIL wrap_next_addr: got %h want 000000", mem_addr);
        end
    endtask

    task automatic test_branch_in_req();
        bit ok, sv;
        mem_lat = 4;
        instr_ready = 1'b1;
        do_reset(24'h000040);
        wait_req(1'b0, ok, sv);
        pulse_branch(24'h000200);
        @(negedge clock);
        checks++;
        if (pc_load_en !== 1'b1 || pc_next !== 24'h000200 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL branch_req_load: got ld=%0b next=%h req=%0b want ld=1 next=000200 req=1",
                     pc_load_en, pc_next, mem_req);
        end
        wait_req(1'b1, ok, sv);
        checks++;
        if (sv !== 1'b0) begin
            failures++;
            $display("FAIL branch_req_discard: got instr_valid seen=%0b want 0", sv);
        end
        checks++;
        if (mem_addr !== 24'h000200) begin
            failures++;
            $display("FAIL branch_req_next_addr: got %h want 000200", mem_addr);
        end
        wait_valid(ok);
        checks++;
        if (instr_pc !== 24'h000200 || instr_data !== word_of(24'h000200)) begin
            failures++;
            $display("FAIL branch_req_instr: got pc=%h data=%h want pc=000200", instr_pc, instr_data);
        end
    endtask

    task automatic test_hold_and_squash();
        bit ok, sv, bad;
        logic [31:0] d0;
        logic [23:0] p0;
        mem_lat = 2;
        instr_ready = 1'b0;
        do_reset(24'h000080);
        wait_valid(ok);
        d0 = instr_data;
        p0 = instr_pc;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (instr_valid !== 1'b1 || instr_data !== d0 || instr_pc !== p0 || mem_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL hold_stable: got v=%0b d=%h pc=%h req=%0b want v=1 d=%h pc=%h req=0",
                     instr_valid, instr_data, instr_pc, mem_req, d0, p0);
        end
        pulse_branch(24'h000300);
        @(negedge clock);
        checks++;
        if (instr_valid !== 1'b0 || pc_load_en !== 1'b1 || pc_next !== 24'h000300) begin
            failures++;
            $display("FAIL hold_squash: got v=%0b ld=%0b next=%h want v=0 ld=1 next=000300",
                     instr_valid, pc_load_en, pc_next);
        end
        instr_ready = 1'b1;
        wait_req(1'b1, ok, sv);
        checks++;
        if (mem_addr !== 24'h000300 || sv !== 1'b0) begin
            failures++;
            $display("FAIL hold_next_addr: got addr=%h stray_valid=%0b want addr=000300 stray_valid=0",
                     mem_addr, sv);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, sv;
        mem_lat = 6;
        instr_ready = 1'b1;
        stall = 1'b0;
        do_reset(24'h000120);
        wait_req(1'b0, ok, sv);
        @(posedge clock);
        #2 stall = 1'b1;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, instr_valid, instr_data, instr_pc, pc_load_en, pc_next, fetch_err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: got req=%0b addr=%h v=%0b ld=%0b nx=%h err=%0b want all 0",
                     mem_req, mem_addr, instr_valid, pc_load_en, pc_next, fetch_err);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 inj_ack = 1'b1;
        @(posedge clock);
        #1 inj_ack = 1'b0;
        @(negedge clock);
        checks++;
        if (instr_valid !== 1'b0 || pc_load_en !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_late_ack: got v=%0b ld=%0b req=%0b want 0 0 0", instr_valid, pc_load_en, mem_req);
        end
        stall = 1'b0;
        wait_req(1'b1, ok, sv);
        checks++;
        if (mem_addr !== 24'h000120) begin
            failures++;
            $display("FAIL reset_restart_addr: got %h want 000120", mem_addr);
        end
        wait_valid(ok);
        checks++;
        if (instr_pc !== 24'h000120 || instr_data !== word_of(24'h000120)) begin
            failures++;
            $display("FAIL reset_restart_instr: got pc=%h data=%h want pc=000120", instr_pc, instr_data);
        end
    endtask

    task automatic test_timeout();
        bit ok, sv, early, active;
        int unsigned cnt;
        mem_mute = 1'b1;
        instr_ready = 1'b1;
        do_reset(24'h000090);
        wait_req(1'b0, ok, sv);
        cnt = 1;
        early = fetch_err;
        while (cnt < 40) begin
            @(negedge clock);
            if (!mem_req) break;
            if (fetch_err) early = 1'b1;
            cnt++;
        end
        checks++;
        if (cnt !== 15 || early) begin
            failures++;
            $display("FAIL timeout_req_cycles: got %0d cycles (early_err=%0b) want 15 (early_err=0)", cnt, early);
        end
        checks++;
        if (fetch_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err: got fetch_err=%0b want 1", fetch_err);
        end
        mem_mute = 1'b0;
        active = 1'b0;
        pulse_branch(24'h000500);
        repeat (20) begin
            @(negedge clock);
            if (mem_req || pc_load_en || instr_valid || !fetch_err) active = 1'b1;
        end
        checks++;
        if (active) begin
            failures++;
            $display("FAIL timeout_terminal: got activity=%0b want 0", active);
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_pc, start_pc, prev_addr, prev_tgt, prev_ipc;
        logic [31:0] prev_data;
        bit prev_req, prev_valid, prev_ready, prev_branch, prev_stall;
        int unsigned accepted;
        start_pc = 24'hFFFFF0 | 24'($urandom_range(0, 15));
        mem_rand_lat = 1'b1;
        stall = 1'b0;
        instr_ready = 1'b1;
        do_reset(start_pc);
        exp_pc = start_pc;
        accepted = 0;
        prev_req = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_branch = 1'b0; prev_stall = 1'b0;
        prev_addr = '0; prev_tgt = '0; prev_ipc = '0; prev_data = '0;
        for (int it = 0; it < 3000; it++) begin
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr_data !== word_of(exp_pc)) begin
                    failures++;
                    $display("FAIL rand_instr @%0d: got pc=%h data=%h want pc=%h data=%h", it,
                             instr_pc, instr_data, exp_pc, word_of(exp_pc));
                end
            end
            if (mem_req || instr_valid) begin
                checks++;
                if (mem_req && instr_valid) begin
                    failures++;
                    $display("FAIL rand_overlap @%0d: got req=1 valid=1 want not both", it);
                end
            end
            if (mem_req && !prev_req) begin
                checks++;
                if (mem_addr !== exp_pc || prev_stall || prev_branch) begin
                    failures++;
                    $display("FAIL rand_launch @%0d: got addr=%h stall=%0b br=%0b want addr=%h stall=0 br=0",
                             it, mem_addr, prev_stall, prev_branch, exp_pc);
                end
            end
            if (mem_req && prev_req) begin
                checks++;
                if (mem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL rand_addr_stable @%0d: got %h want %h", it, mem_addr, prev_addr);
                end
            end
            if (prev_valid && !prev_ready && !prev_branch) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_ipc || instr_data !== prev_data) begin
                    failures++;
                    $display("FAIL rand_hold @%0d: got v=%0b pc=%h d=%h want v=1 pc=%h d=%h", it,
                             instr_valid, instr_pc, instr_data, prev_ipc, prev_data);
                end
            end
            if (pc_load_en) begin
                checks++;
                if (prev_branch ? (pc_next !== prev_tgt)
                                : (instr_valid !== 1'b1 || pc_next !== instr_pc + 24'd1)) begin
                    failures++;
                    $display("FAIL rand_pc_load @%0d: got next=%h br=%0b want %h", it, pc_next, prev_branch,
                             prev_branch ? prev_tgt : instr_pc + 24'd1);
                end
            end
            if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + 24'd1;
                accepted++;
            end
            if (branch_valid) exp_pc = branch_target;
            prev_req = mem_req; prev_addr = mem_addr; prev_valid = instr_valid; prev_ready = instr_ready;
            prev_ipc = instr_pc; prev_data = instr_data; prev_branch = branch_valid; prev_tgt = branch_target;
            prev_stall = stall;
            @(posedge clock);
            #1;
            stall = ($urandom_range(0, 99) < 20);
            instr_ready = ($urandom_range(0, 99) < 70);
            branch_valid = !branch_valid && ($urandom_range(0, 99) < 4);
            branch_target = ($urandom_range(0, 3) == 0) ? (24'hFFFFFC | 24'($urandom_range(0, 3)))
                                                        : 24'($urandom);
            @(negedge clock);
        end
        branch_valid = 1'b0;
        mem_rand_lat = 1'b0;
        checks++;
        if (accepted < 100) begin
            failures++;
            $display("FAIL rand_progress: got %0d accepted words want >= 100", accepted);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_branch_in_req();
        test_hold_and_squash();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
